// File: rtl/pipe_ctl.sv
// Pipeline hazard / flush / stack-wait controller driving PC enable and IR load/bubble.
// Optional stall counter enabled by defining PIPE_CTL_PERF_EN.
module pipe_ctl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  dec_a_addr,
    input  logic [3:0]  dec_b_addr,
    input  logic        dec_uses_a,
    input  logic        dec_uses_b,
    input  logic [3:0]  ir_c_addr,
    input  logic        ir_reg_write,
    input  logic        ir_data_read,
    input  logic        jump_taken,
    input  logic        stack_busy,
    output logic        pc_en,
    output logic        ir_load,
    output logic        ir_bubble,
    output logic [1:0]  state,
    output logic [15:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        STACK_WAIT = 2'd3
    } state_t;

    // The jump cycle itself is the first bubble, so FLUSH covers the remainder.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 32'd1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] flush_cnt_r;
    logic [2:0] flush_cnt_nxt_s;
    logic       hazard_s;
    logic       pc_en_s;
    logic       ir_load_s;
    logic       ir_bubble_s;

    assign hazard_s = ir_data_read & ir_reg_write &
                      ((dec_uses_a & (ir_c_addr == dec_a_addr)) |
                       (dec_uses_b & (ir_c_addr == dec_b_addr)));

    // State and flush counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= RUN;
            flush_cnt_r <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
        end
    end

    // Next-state and raw pipeline control decode.
    always_comb begin
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        pc_en_s         = 1'b0;
        ir_load_s       = 1'b0;
        ir_bubble_s     = 1'b0;
        case (state_r)
            RUN, LOAD_STALL: begin
                if (jump_taken) begin
                    pc_en_s     = 1'b1;
                    ir_bubble_s = 1'b1;
                    if (FLUSH_CYCLES == 32'd1) begin
                        state_nxt_s     = RUN;
                        flush_cnt_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s     = FLUSH;
                        flush_cnt_nxt_s = FLUSH_INIT;
                    end
                end else if (state_r == LOAD_STALL) begin
                    pc_en_s     = 1'b1;
                    ir_load_s   = 1'b1;
                    state_nxt_s = RUN;
                end else if (stack_busy) begin
                    state_nxt_s = STACK_WAIT;
                end else if (hazard_s) begin
                    ir_bubble_s = 1'b1;
                    state_nxt_s = LOAD_STALL;
                end else begin
                    pc_en_s     = 1'b1;
                    ir_load_s   = 1'b1;
                    state_nxt_s = RUN;
                end
            end
            FLUSH: begin
                pc_en_s     = 1'b1;
                ir_bubble_s = 1'b1;
                if (flush_cnt_r <= 3'd1) begin
                    flush_cnt_nxt_s = 3'd0;
                    state_nxt_s     = RUN;
                end else begin
                    flush_cnt_nxt_s = flush_cnt_r - 3'd1;
                    state_nxt_s     = FLUSH;
                end
            end
            STACK_WAIT: begin
                if (!stack_busy) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = STACK_WAIT;
                end
            end
            default: begin
                ir_bubble_s     = 1'b1;
                state_nxt_s     = RUN;
                flush_cnt_nxt_s = 3'd0;
            end
        endcase
    end

    // Reset overrides the decode asynchronously so the IR fills with NOPs.
    assign pc_en     = RST_N & pc_en_s;
    assign ir_load   = RST_N & ir_load_s;
    assign ir_bubble = ~RST_N | ir_bubble_s;
    assign state     = state_r;

`ifdef PIPE_CTL_PERF_EN
    logic [15:0] perf_cnt_r;

    // Saturating count of cycles where the pipeline does not accept a real instruction.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perf_cnt_r <= 16'h0000;
        end else if ((!pc_en || ir_bubble) && (perf_cnt_r != 16'hFFFF)) begin
            perf_cnt_r <= perf_cnt_r + 16'h0001;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign perf_stall_cnt = perf_cnt_r;
`else
    assign perf_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// Randomized self-checking bench for pipe_ctl against a bubble-budget reference model.
module tb_pipe_ctl;
    localparam int FC = 2;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  dec_a_addr, dec_b_addr, ir_c_addr;
    logic        dec_uses_a, dec_uses_b, ir_reg_write, ir_data_read;
    logic        jump_taken, stack_busy;
    logic        pc_en, ir_load, ir_bubble;
    logic [1:0]  state;
    logic [15:0] perf_stall_cnt;

    pipe_ctl #(.FLUSH_CYCLES(FC)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .dec_a_addr(dec_a_addr), .dec_b_addr(dec_b_addr),
        .dec_uses_a(dec_uses_a), .dec_uses_b(dec_uses_b),
        .ir_c_addr(ir_c_addr), .ir_reg_write(ir_reg_write), .ir_data_read(ir_data_read),
        .jump_taken(jump_taken), .stack_busy(stack_busy),
        .pc_en(pc_en), .ir_load(ir_load), .ir_bubble(ir_bubble),
        .state(state), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining flush bubbles, stack-wait flag, load-stall flag.
    int bub_left = 0;
    bit in_stack = 1'b0;
    bit in_load  = 1'b0;
    int perf_m   = 0;
    bit e_pc, e_ld, e_bub;
    int e_state;
    logic       o_pc, o_ld, o_bub;
    logic [1:0] o_state;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit hz;
        hz = ir_data_read && ir_reg_write &&
             ((dec_uses_a && ir_c_addr == dec_a_addr) || (dec_uses_b && ir_c_addr == dec_b_addr));
        e_pc = 1'b0; e_ld = 1'b0; e_bub = 1'b0;
        if (bub_left > 0) begin
            e_state = 2; e_pc = 1'b1; e_bub = 1'b1;
            bub_left--;
        end else if (in_stack) begin
            e_state = 3;
            if (!stack_busy) in_stack = 1'b0;
        end else begin
            e_state = in_load ? 1 : 0;
            if (jump_taken) begin
                e_pc = 1'b1; e_bub = 1'b1;
                bub_left = FC - 1;
                in_load = 1'b0;
            end else if (in_load) begin
                e_pc = 1'b1; e_ld = 1'b1;
                in_load = 1'b0;
            end else if (stack_busy) begin
                in_stack = 1'b1;
            end else if (hz) begin
                e_bub = 1'b1;
                in_load = 1'b1;
            end else begin
                e_pc = 1'b1; e_ld = 1'b1;
            end
        end
    endtask

    // Called at a falling edge; applies inputs, checks this cycle, returns at the next falling edge.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic ua, input logic ub, input logic rw, input logic dr,
                         input logic j, input logic sb);
        dec_a_addr = a; dec_b_addr = b; ir_c_addr = c;
        dec_uses_a = ua; dec_uses_b = ub; ir_reg_write = rw; ir_data_read = dr;
        jump_taken = j; stack_busy = sb;
        #1;
        model_eval();
        o_pc = pc_en; o_ld = ir_load; o_bub = ir_bubble; o_state = state;
        chk("pc_en", {31'd0, pc_en}, {31'd0, e_pc});
        chk("ir_load", {31'd0, ir_load}, {31'd0, e_ld});
        chk("ir_bubble", {31'd0, ir_bubble}, {31'd0, e_bub});
        chk("state", {30'd0, state}, e_state);
`ifdef PIPE_CTL_PERF_EN
        chk("perf", {16'd0, perf_stall_cnt}, perf_m);
        if ((!e_pc || e_bub) && perf_m < 65535) perf_m++;
`else
        chk("perf", {16'd0, perf_stall_cnt}, 32'd0);
`endif
        @(negedge CLK);
    endtask

    task automatic nop();
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_ir_load", {31'd0, ir_load}, 32'd0);
        chk("rst_ir_bubble", {31'd0, ir_bubble}, 32'd1);
        chk("rst_perf", {16'd0, perf_stall_cnt}, 32'd0);
        bub_left = 0; in_stack = 1'b0; in_load = 1'b0; perf_m = 0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        dec_a_addr = 4'd0; dec_b_addr = 4'd0; ir_c_addr = 4'd0;
        dec_uses_a = 1'b0; dec_uses_b = 1'b0; ir_reg_write = 1'b0; ir_data_read = 1'b0;
        jump_taken = 1'b0; stack_busy = 1'b0;
        @(negedge CLK);
        do_reset();

        // Load-use stall: one bubble, then a load from LOAD_STALL, back to RUN.
        drive(4'd5, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lu_pc0", {31'd0, o_pc}, 32'd0);
        chk("lu_bub", {31'd0, o_bub}, 32'd1);
        drive(4'd5, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lu_state1", {30'd0, o_state}, 32'd1);
        chk("lu_load", {31'd0, o_ld}, 32'd1);
        nop();
        chk("lu_state0", {30'd0, o_state}, 32'd0);

        // Jump: exactly FC bubbles, state 0,2,0.
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("jmp_bub0", {31'd0, o_bub}, 32'd1);
        chk("jmp_pc0", {31'd0, o_pc}, 32'd1);
        nop();
        chk("jmp_state2", {30'd0, o_state}, 32'd2);
        chk("jmp_bub1", {31'd0, o_bub}, 32'd1);
        nop();
        chk("jmp_state0", {30'd0, o_state}, 32'd0);
        chk("jmp_load", {31'd0, o_ld}, 32'd1);

        // Stack wait with jumps ignored.
        for (int i = 0; i < 4; i++) begin
            drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, (i > 0) ? 1'b1 : 1'b0, 1'b1);
            chk("stk_pc", {31'd0, o_pc}, 32'd0);
            chk("stk_load", {31'd0, o_ld}, 32'd0);
        end
        chk("stk_state3", {30'd0, o_state}, 32'd3);
        nop();
        nop();
        chk("stk_run", {30'd0, o_state}, 32'd0);

        // Priority: jump beats stack_busy and hazard.
        drive(4'd7, 4'd0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("prio_bub", {31'd0, o_bub}, 32'd1);
        chk("prio_pc", {31'd0, o_pc}, 32'd1);

        // Reset while in FLUSH with one bubble left.
        chk("flush_state", {30'd0, state}, 32'd2);
        do_reset();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                drive(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            end
        end

`ifdef PIPE_CTL_PERF_EN
        for (int n = 0; n < 70000; n++) begin
            drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("perf_sat", {16'd0, perf_stall_cnt}, 32'h0000FFFF);
`else
        for (int n = 0; n < 8; n++) begin
            drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("perf_zero", {16'd0, perf_stall_cnt}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
